// File: rtl/hc595_ctrl.sv
// hc595_ctrl: shifts {seg,sel} MSB-first into a 74HC595 chain, then pulses stcp to latch it.
// Optional build macro HC595_CHG_ONLY_EN: a new frame is shifted only when the pattern changes.
module hc595_ctrl #(
  parameter int HALF = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] seg,
  input  logic [5:0] sel,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe,
  output logic       frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam logic [8:0] CNT_LAST = 9'(2 * HALF - 1);
  localparam logic [8:0] CNT_MID  = 9'(HALF);

  logic [1:0]  state_q, state_d;
  logic [8:0]  cnt_div_q, cnt_div_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [13:0] frame_q, frame_d;
  logic        ds_q, ds_d;
  logic        shcp_q, shcp_d;
  logic        stcp_q, stcp_d;
  logic        oe_q, oe_d;
  logic        frame_done_q, frame_done_d;
  logic        period_end;
  logic        capture_ok;

  assign period_end = (cnt_div_q == CNT_LAST);

  // oe_q is still 1 exactly while no frame has completed since reset.
`ifdef HC595_CHG_ONLY_EN
  assign capture_ok = oe_q || ({seg, sel} != frame_q);
`else
  assign capture_ok = 1'b1;
`endif

  always_comb begin
    cnt_div_d    = period_end ? 9'd0 : cnt_div_q + 9'd1;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    frame_d      = frame_q;
    ds_d         = ds_q;
    shcp_d       = shcp_q;
    stcp_d       = stcp_q;
    oe_d         = oe_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (period_end && capture_ok) begin
          frame_d   = {seg, sel};
          bit_cnt_d = 4'd0;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (cnt_div_q == 9'd0) begin
          ds_d   = frame_q[4'd13 - bit_cnt_q];
          shcp_d = 1'b0;
        end else if (cnt_div_q == CNT_MID) begin
          shcp_d = 1'b1;
        end else begin
          shcp_d = shcp_q;
        end
        if (period_end) begin
          if (bit_cnt_q == 4'd13) begin
            state_d = LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      LATCH: begin
        shcp_d = 1'b0;
        if (cnt_div_q == 9'd0) begin
          stcp_d = 1'b1;
        end else if (cnt_div_q == CNT_MID) begin
          stcp_d = 1'b0;
        end else begin
          stcp_d = stcp_q;
        end
        if (period_end) begin
          frame_done_d = 1'b1;
          oe_d         = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = LATCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_div_q    <= 9'd0;
      bit_cnt_q    <= 4'd0;
      frame_q      <= 14'd0;
      ds_q         <= 1'b0;
      shcp_q       <= 1'b0;
      stcp_q       <= 1'b0;
      oe_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_div_q    <= cnt_div_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_q      <= frame_d;
      ds_q         <= ds_d;
      shcp_q       <= shcp_d;
      stcp_q       <= stcp_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ds         = ds_q;
  assign shcp       = shcp_q;
  assign stcp       = stcp_q;
  assign oe         = oe_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: three instances (HALF=2,1,5) share stimulus; each is checked against a
// frame-level model built from the input history (capture edge, bit order, frame timing).
module tb_hc595_ctrl;

  logic       clk     = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] seg     = 8'hC0;
  logic [5:0] sel     = 6'h3F;
  logic [2:0] ds_w, shcp_w, stcp_w, oe_w, fd_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hc595_ctrl #(.HALF(2)) u_h2 (.sys_clk(clk), .sys_rst(sys_rst), .seg(seg), .sel(sel),
    .ds(ds_w[0]), .shcp(shcp_w[0]), .stcp(stcp_w[0]), .oe(oe_w[0]), .frame_done(fd_w[0]));
  hc595_ctrl #(.HALF(1)) u_h1 (.sys_clk(clk), .sys_rst(sys_rst), .seg(seg), .sel(sel),
    .ds(ds_w[1]), .shcp(shcp_w[1]), .stcp(stcp_w[1]), .oe(oe_w[1]), .frame_done(fd_w[1]));
  hc595_ctrl #(.HALF(5)) u_h5 (.sys_clk(clk), .sys_rst(sys_rst), .seg(seg), .sel(sel),
    .ds(ds_w[2]), .shcp(shcp_w[2]), .stcp(stcp_w[2]), .oe(oe_w[2]), .frame_done(fd_w[2]));

  function automatic int half_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  // Observation record filled by collect()
  logic [13:0] in_at [0:1023];
  logic        gb [0:2][0:255];
  int          fdc [0:2][0:31];
  int nb [3], nfd [3], st_hi [3], overlap [3], oe_bad [3], per_bad [3], last_rise [3];
  logic        prev_shcp [3];
  logic        fd_seen [3];

  task automatic apply_reset();
    sys_rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      prev_shcp[i] = 1'b0;
      fd_seen[i]   = 1'b0;
    end
    sys_rst = 1'b0;
  endtask

  // mode 0: inputs constant, 1: seg C0->F9 seen at edge 28, 2: random input changes
  task automatic collect(input int ncyc, input int mode);
    for (int i = 0; i < 3; i++) begin
      nb[i] = 0; nfd[i] = 0; st_hi[i] = 0; overlap[i] = 0;
      oe_bad[i] = 0; per_bad[i] = 0; last_rise[i] = 0;
    end
    in_at[1] = {seg, sel};
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (shcp_w[i] === 1'b1 && prev_shcp[i] === 1'b0) begin
          if ((nb[i] % 14) != 0 && (c - last_rise[i]) != 2 * half_of(i)) per_bad[i]++;
          if (nb[i] < 256) gb[i][nb[i]] = ds_w[i];
          nb[i]++;
          last_rise[i] = c;
        end
        if (stcp_w[i] === 1'b1) begin
          st_hi[i]++;
          if (shcp_w[i] !== 1'b0) overlap[i]++;
        end
        if (fd_w[i] === 1'b1) begin
          if (nfd[i] < 32) fdc[i][nfd[i]] = c;
          nfd[i]++;
          fd_seen[i] = 1'b1;
        end else if (oe_w[i] !== (fd_seen[i] ? 1'b0 : 1'b1)) begin
          oe_bad[i]++;
        end
        prev_shcp[i] = shcp_w[i];
      end
      if (mode == 1 && c == 27) seg = 8'hF9;
      if (mode == 2 && $urandom_range(0, 11) == 0) {seg, sel} = 14'($urandom);
      if (c + 1 < 1024) in_at[c + 1] = {seg, sel};
    end
  endtask

  task automatic run_check(input string name, input int ncyc, input int mode);
    apply_reset();
    collect(ncyc, mode);
    for (int i = 0; i < 3; i++) begin
      int h;
      int exp_nfd;
      h       = half_of(i);
      exp_nfd = ncyc / (32 * h);
      checks++;
      if (nfd[i] != exp_nfd) begin
        errors++;
        $display("FAIL %s frame_count inst%0d got %0d expected %0d", name, i, nfd[i], exp_nfd);
      end
      for (int n = 0; n < exp_nfd && n < nfd[i] && n < 32; n++) begin
        checks++;
        if (fdc[i][n] != 32 * h * (n + 1)) begin
          errors++;
          $display("FAIL %s frame_done_cycle inst%0d frame%0d got %0d expected %0d",
                   name, i, n, fdc[i][n], 32 * h * (n + 1));
        end
      end
      checks++;
      if (nb[i] != 14 * exp_nfd) begin
        errors++;
        $display("FAIL %s shcp_rises inst%0d got %0d expected %0d", name, i, nb[i], 14 * exp_nfd);
      end
      for (int n = 0; n < exp_nfd && 14 * n + 13 < 256; n++) begin
        logic [13:0] got;
        logic [13:0] exp;
        exp = in_at[32 * h * n + 2 * h];
        for (int k = 0; k < 14; k++) got[13 - k] = gb[i][14 * n + k];
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s frame_bits inst%0d frame%0d got %h expected %h", name, i, n, got, exp);
        end
      end
      checks++;
      if (st_hi[i] != h * exp_nfd) begin
        errors++;
        $display("FAIL %s stcp_high_cycles inst%0d got %0d expected %0d", name, i, st_hi[i], h * exp_nfd);
      end
      checks++;
      if (overlap[i] != 0 || oe_bad[i] != 0 || per_bad[i] != 0) begin
        errors++;
        $display("FAIL %s protocol inst%0d got overlap=%0d oe_bad=%0d period_bad=%0d expected all 0",
                 name, i, overlap[i], oe_bad[i], per_bad[i]);
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ds_w[i], shcp_w[i], stcp_w[i], oe_w[i], fd_w[i]} !== 5'b00010) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got %b expected 00010", i,
                 {ds_w[i], shcp_w[i], stcp_w[i], oe_w[i], fd_w[i]});
      end
    end
  endtask

  task automatic test_basic_frame();
    seg = 8'hC0;
    sel = 6'h3F;
    run_check("basic_c0_3f", 320, 0);
  endtask

  task automatic test_seg_change_mid();
    seg = 8'hC0;
    sel = 6'(($urandom));
    run_check("seg_change_mid", 640, 1);
  endtask

  task automatic test_random_frames();
    for (int r = 0; r < 2; r++) begin
      {seg, sel} = 14'($urandom);
      run_check("random_frames", 640, 2);
    end
  endtask

  task automatic test_reset_mid();
    seg = 8'hA5;
    sel = 6'h2A;
    apply_reset();
    repeat (35) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ds_w[i], shcp_w[i], stcp_w[i], oe_w[i], fd_w[i]} !== 5'b00010) begin
        errors++;
        $display("FAIL reset_mid inst%0d got %b expected 00010", i,
                 {ds_w[i], shcp_w[i], stcp_w[i], oe_w[i], fd_w[i]});
      end
    end
    run_check("after_reset_mid", 320, 0);
  endtask

`ifdef HC595_CHG_ONLY_EN
  task automatic test_chg_only();
    seg = 8'hC0;
    sel = 6'h3F;
    apply_reset();
    collect(640, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (nfd[i] != 1 || nb[i] != 14) begin
        errors++;
        $display("FAIL chg_only_const inst%0d got frames=%0d rises=%0d expected 1 and 14", i, nfd[i], nb[i]);
      end
    end
    sel = 6'h3E;
    collect(640, 0);
    for (int i = 0; i < 3; i++) begin
      logic [13:0] got;
      for (int k = 0; k < 14; k++) got[13 - k] = gb[i][k];
      checks++;
      if (nfd[i] != 1 || nb[i] != 14 || got !== {8'hC0, 6'h3E}) begin
        errors++;
        $display("FAIL chg_only_new inst%0d got frames=%0d rises=%0d bits=%h expected 1 14 %h",
                 i, nfd[i], nb[i], got, {8'hC0, 6'h3E});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef HC595_CHG_ONLY_EN
    test_chg_only();
`else
    test_basic_frame();
    test_seg_change_mid();
    test_random_frames();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc595_ctrl.md
HC595_CTRL -- requirements
Module: hc595_ctrl

Interface
REQ-001 SHALL provide parameter HALF, default 2, meaning sys_clk cycles per shcp half-period (legal range 1..255).
REQ-002 SHALL provide port sys_clk  input  1  system clock; the block uses this single clock and all logic is clocked on its rising edge.
REQ-003 SHALL provide port sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port seg  input  8  segment pattern from the display driver.
REQ-005 SHALL provide port sel  input  6  digit-select pattern from the display driver.
REQ-006 SHALL provide port ds  output  1  serial data to the 74HC595 chain.
REQ-007 SHALL provide port shcp  output  1  shift clock to the 74HC595 chain.
REQ-008 SHALL provide port stcp  output  1  storage (latch) clock to the 74HC595 chain.
REQ-009 SHALL provide port oe  output  1  74HC595 output enable, active-low.
REQ-010 SHALL provide port frame_done  output  1  one-cycle pulse at the end of each latched frame.

Function
REQ-011 SHALL keep a free-running divider cnt_div that counts 0..2*HALF-1 and then wraps to 0; one "period" is one full count.
REQ-012 SHALL implement states IDLE, SHIFT and LATCH, with transitions taken only on the edge where cnt_div==2*HALF-1.
REQ-013 IDLE: at the end of the period SHALL capture frame F={seg,sel} (14 bits), clear bit_cnt, and go to SHIFT.
REQ-014 SHIFT: on the edge where cnt_div==0 SHALL drive ds<=F[13-bit_cnt] and shcp<=0.
REQ-015 SHIFT: on the edge where cnt_div==HALF SHALL drive shcp<=1.
REQ-016 SHIFT: at the end of the period SHALL increment bit_cnt; if bit_cnt==13, SHALL go to LATCH instead.
REQ-017 Bit order SHALL be seg[7] first through seg[0], then sel[5] through sel[0] (sel[0] last).
REQ-018 LATCH: shcp SHALL stay 0 and ds SHALL hold its value.
REQ-019 LATCH: stcp SHALL be driven 1 on the edge where cnt_div==0 and 0 on the edge where cnt_div==HALF.
REQ-020 LATCH: at the end of the period SHALL pulse frame_done=1 for exactly one cycle and go to IDLE.
REQ-021 One frame SHALL be 16 periods (1 IDLE + 14 SHIFT + 1 LATCH), i.e. 64 sys_clk cycles at HALF=2.
REQ-022 seg/sel changes during SHIFT or LATCH SHALL NOT affect the frame in flight; they take effect at the next IDLE capture.
REQ-023 oe SHALL stay 1 until the first frame_done after reset, then SHALL be 0 permanently.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While sys_rst=1: state=IDLE, cnt_div=0, bit_cnt=0, F=0, ds=0, shcp=0, stcp=0, oe=1, frame_done=0.
REQ-026 sys_rst asserted mid-frame SHALL abort the frame on the next edge, with no further shcp or stcp edges; after release, operation restarts from IDLE.

Configuration
REQ-027 Macro HC595_CHG_ONLY_EN, when defined: IDLE SHALL capture and go to SHIFT only if {seg,sel} differs from the last latched F, or if no frame has completed since reset; otherwise it stays in IDLE with all outputs holding.
REQ-028 Macro HC595_CHG_ONLY_EN, when not defined: frames SHALL repeat continuously, one every 16 periods.

Verification
REQ-029 HALF=2; seg=8'hC0, sel=6'h3F; release reset -> ds sampled at shcp rises = 1,1,0,0,0,0,0,0,1,1,1,1,1,1; stcp high for 2 cycles; frame_done at cycle 64 after release; oe then 0.
REQ-030 Change seg from 8'hC0 to 8'hF9 during bit 5 of a frame -> that frame still shifts 8'hC0; the next frame shifts 8'hF9.
REQ-031 Assert sys_rst during bit 7 -> next edge gives shcp=0, stcp=0, ds=0, oe=1; no frame_done; after release the full frame completes 64 cycles later.
REQ-032 HALF=1 -> shcp period 2 cycles, frame 32 cycles; HALF=5 -> shcp period 10 cycles, frame 160 cycles; bit pattern as in REQ-029.
REQ-033 HC595_CHG_ONLY_EN defined, inputs held constant -> exactly one frame_done after reset and no later shcp edges; change sel to 6'h3E -> one new frame ending with sel[0]=0.
REQ-034 HC595_CHG_ONLY_EN not defined, inputs constant -> frame_done every 64 cycles; stcp never high while shcp toggles.
